// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for the LED-matrix display path: one-hot row strobe with
// per-row dwell and optional blanking, frame-buffer read address and frame pulses.
module matrix_scan_ctrl #(
   parameter  int ROWS  = 8,
   parameter  int IDX_W = 7,
   parameter  int DWELL = 1,
   parameter  int BLANK = 0,
   localparam int RW    = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [IDX_W-1:0] base_idx,
   output logic [ROWS-1:0]  row,
   output logic [RW-1:0]    row_num,
   output logic [IDX_W-1:0] addr,
   output logic             blank,
   output logic             frame_start,
   output logic             frame_done
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [ROWS-1:0] ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_BLANK} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    dwell_cnt_q, dwell_cnt_d;
   logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
   logic             dir_q, dir_d;
   logic [IDX_W-1:0] base_q, base_d;
   logic [RW-1:0]    row_num_q, row_num_d;
   logic [ROWS-1:0]  row_q, row_d;
   logic [IDX_W-1:0] addr_q, addr_d;
   logic             blank_q, blank_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_done_q, frame_done_d;
   logic             start, adv, go_idle, last_d;

   function automatic logic is_last(input logic [RW-1:0] n, input logic d);
      return d ? (n == '0) : (n == ROW_LAST);
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d       = state_q;
      dwell_cnt_d   = dwell_cnt_q;
      blank_cnt_d   = blank_cnt_q;
      dir_d         = dir_q;
      base_d        = base_q;
      row_num_d     = row_num_q;
      frame_start_d = 1'b0;
      start         = 1'b0;
      adv           = 1'b0;
      go_idle       = 1'b0;

      case (state_q)
         S_IDLE: start = en;
         S_SCAN: begin
            if (dwell_cnt_q == DWELL_LAST) begin
               dwell_cnt_d = '0;
               if (BLANK > 0) begin
                  state_d     = S_BLANK;
                  blank_cnt_d = '0;
               end else if (is_last(row_num_q, dir_q)) begin
                  start   = en;
                  go_idle = !en;
               end else begin
                  adv = 1'b1;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
         end
         S_BLANK: begin
            if (blank_cnt_q == BLANK_LAST) begin
               blank_cnt_d = '0;
               if (is_last(row_num_q, dir_q)) begin
                  start   = en;
                  go_idle = !en;
               end else begin
                  adv = 1'b1;
               end
            end else begin
               blank_cnt_d = blank_cnt_q + 1'b1;
            end
         end
         default: go_idle = 1'b1;
      endcase

      // Frame start re-latches dir/base; mid-frame changes never reach the scan.
      if (start) begin
         dir_d         = dir;
         base_d        = base_idx;
         row_num_d     = dir ? ROW_LAST : '0;
         state_d       = S_SCAN;
         dwell_cnt_d   = '0;
         frame_start_d = 1'b1;
      end else if (adv) begin
         row_num_d   = dir_q ? row_num_q - 1'b1 : row_num_q + 1'b1;
         state_d     = S_SCAN;
         dwell_cnt_d = '0;
      end else if (go_idle) begin
         state_d = S_IDLE;
      end

      // Outputs are derived from next-state values so they register alongside the state.
      row_d   = (state_d == S_SCAN) ? (ROW_ONE << row_num_d) : '0;
      blank_d = (state_d != S_SCAN);
      addr_d  = base_d + IDX_W'(row_num_d);
      last_d  = is_last(row_num_d, dir_d);
      if (BLANK > 0)
         frame_done_d = (state_d == S_BLANK) && (blank_cnt_d == BLANK_LAST) && last_d;
      else
         frame_done_d = (state_d == S_SCAN) && (dwell_cnt_d == DWELL_LAST) && last_d;
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
      if (rst) begin
         state_q       <= S_IDLE;
         dwell_cnt_q   <= '0;
         blank_cnt_q   <= '0;
         dir_q         <= 1'b0;
         base_q        <= '0;
         row_num_q     <= '0;
         row_q         <= '0;
         addr_q        <= '0;
         blank_q       <= 1'b1;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         dwell_cnt_q   <= dwell_cnt_d;
         blank_cnt_q   <= blank_cnt_d;
         dir_q         <= dir_d;
         base_q        <= base_d;
         row_num_q     <= row_num_d;
         row_q         <= row_d;
         addr_q        <= addr_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign row         = row_q;
   assign row_num     = row_num_q;
   assign addr        = addr_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;

endmodule
